uart_rx_os: RTL and testbench

Parametrised 16x-oversampling UART receiver for the FPGA serial link. It is the successor to the fixed 8N1 receiver and sits between the board RX pin and the command/echo logic. It adds configurable data width, parity and stop bits, 3-sample majority voting, an input synchroniser, per-word error flags and a valid/ready output handshake with overrun reporting.

---
 rtl/uart_rx_os_if.sv | 13 +
 rtl/uart_rx_os.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Received-word handshake bundle between uart_rx_os (master) and its consumer (slave).
interface uart_rx_os_if;
  logic [8:0] data;
  logic       valid;
  logic       ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       brk;

  modport master (output data, valid, parity_err, frame_err, overrun, brk, input ready);
  modport slave  (input data, valid, parity_err, frame_err, overrun, brk, output ready);
endinterface

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 2-flop sync, 3-sample majority, parity/stop checks, valid/ready out.
// Optional break detection (BREAK_WAIT state, brk pulse) enabled by defining UART_RX_OS_BREAK_EN.
module uart_rx_os #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  uart_rx_os_if.master rxo
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] CNT_MAX   = TW'(DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_os: CLK_HZ/(BAUD*16) must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
`ifdef UART_RX_OS_BREAK_EN
    , S_BRKW
`endif
  } state_t;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]    sub_q, sub_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    smp_q, smp_d;
  logic [8:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          ferr_q, ferr_d;
  word_t         out_q, out_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
`ifdef UART_RX_OS_BREAK_EN
  logic          stop0_q, stop0_d;
  logic          brk_q, brk_d;
  logic          first0;
`endif

  logic rxs, tick, maj, eval, bit_end, perr_w, fe_w;

  assign sync_d  = {sync_q[0], rx};
  assign rxs     = sync_q[1];
  assign tick    = (cnt_q == CNT_MAX);
  assign eval    = tick && (sub_q == 4'd9);
  assign bit_end = tick && (sub_q == 4'd15);
  // smp_q[0] holds the tick-7 sample, smp_q[1] the tick-8 sample; rxs is the tick-9 sample.
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign perr_w  = (PARITY == 1) ? ~(^sh_q ^ par_q) :
                   (PARITY == 2) ?  (^sh_q ^ par_q) : 1'b0;
  assign fe_w    = ferr_q | ~maj;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    sub_d   = tick ? sub_q + 4'd1 : sub_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_OS_BREAK_EN
    stop0_d = stop0_q;
    brk_d   = 1'b0;
    first0  = (bit_q == 4'd0) ? ~maj : stop0_q;
`endif

    if (tick && sub_q == 4'd7) smp_d[0] = rxs;
    if (tick && sub_q == 4'd8) smp_d[1] = rxs;

    if (valid_q && rxo.ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
          sub_d   = '0;
          bit_d   = '0;
          sh_d    = '0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
`ifdef UART_RX_OS_BREAK_EN
          stop0_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (eval && maj) state_d = S_IDLE;
        else if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (eval) sh_d[bit_q] = maj;
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (eval) par_d = maj;
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (eval && bit_q == LAST_STOP) begin
          // Leave at the final evaluation rather than the bit end to tolerate rate skew.
          state_d = S_IDLE;
`ifdef UART_RX_OS_BREAK_EN
          if (sh_q == '0 && first0) begin
            brk_d   = 1'b1;
            state_d = S_BRKW;
            sub_d   = '0;
          end else
`endif
          if (!valid_q || rxo.ready) begin
            out_d.data = sh_q;
            out_d.perr = perr_w;
            out_d.ferr = fe_w;
            valid_d    = 1'b1;
            ovr_d      = 1'b0;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          if (eval) begin
            ferr_d = fe_w;
`ifdef UART_RX_OS_BREAK_EN
            if (bit_q == 4'd0) stop0_d = ~maj;
`endif
          end
          if (bit_end) bit_d = bit_q + 4'd1;
        end
      end
`ifdef UART_RX_OS_BREAK_EN
      S_BRKW: begin
        // sub_q counts consecutive high ticks; any low tick restarts the count.
        if (tick) begin
          if (!rxs) sub_d = '0;
          else if (sub_q == 4'd15) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      sub_q   <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_OS_BREAK_EN
      stop0_q <= 1'b0;
      brk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_OS_BREAK_EN
      stop0_q <= stop0_d;
      brk_q   <= brk_d;
`endif
    end
  end

  assign rxo.data       = out_q.data;
  assign rxo.valid      = valid_q;
  assign rxo.parity_err = out_q.perr;
  assign rxo.frame_err  = out_q.ferr;
  assign rxo.overrun    = ovr_q;
`ifdef UART_RX_OS_BREAK_EN
  assign rxo.brk        = brk_q;
`else
  assign rxo.brk        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 instance and 9E2 instance, DIV=2 (32 clk per bit).
module tb_uart_rx_os;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx8 = 1'b1;
  logic rx9 = 1'b1;
  always #5 clk = ~clk;

  uart_rx_os_if b8 ();
  uart_rx_os_if b9 ();

  uart_rx_os #(.CLK_HZ(32_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u8 (.clk(clk), .rst(rst), .rx(rx8), .rxo(b8));
  uart_rx_os #(.CLK_HZ(32_000_000), .BAUD(1_000_000), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2))
    u9 (.clk(clk), .rst(rst), .rx(rx9), .rxo(b9));

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int vcnt8 = 0, vcnt9 = 0, bcnt8 = 0, vcyc8 = 0;
  logic [8:0] ld8 = '0, ld9 = '0;
  logic lpe8 = 0, lfe8 = 0, lov8 = 0, lpe9 = 0, lfe9 = 0;

  always @(posedge clk) cyc++;

  // Capture every word presented on each output (valid seen at negedge).
  always @(negedge clk) begin
    if (b8.valid) begin
      vcnt8++; vcyc8 = cyc;
      ld8 = b8.data; lpe8 = b8.parity_err; lfe8 = b8.frame_err; lov8 = b8.overrun;
    end
    if (b9.valid) begin
      vcnt9++;
      ld9 = b9.data; lpe9 = b9.parity_err; lfe9 = b9.frame_err;
    end
    if (b8.brk) bcnt8++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setrx(input bit sel, input logic v);
    if (sel) rx9 = v; else rx8 = v;
  endtask

  // Start bit, nb data bits LSB first, optional parity, nstop stop bits (first = stopv).
  // spike >= 0 inverts that data bit for one clk around its tick-8 sample.
  task automatic send(input bit sel, input logic [8:0] d, input int nb, input int par,
                      input bit pflip, input int nstop, input logic stopv, input int spike);
    logic p;
    setrx(sel, 1'b0); clks(32);
    for (int i = 0; i < nb; i++) begin
      setrx(sel, d[i]);
      if (i == spike) begin
        clks(18); setrx(sel, ~d[i]); clks(1); setrx(sel, d[i]); clks(13);
      end else clks(32);
    end
    if (par != 0) begin
      p = (par == 1) ? ~(^d) : (^d);
      setrx(sel, p ^ pflip); clks(32);
    end
    for (int i = 0; i < nstop; i++) begin
      setrx(sel, (i == 0) ? stopv : 1'b1); clks(32);
    end
    setrx(sel, 1'b1);
  endtask

  initial begin
    int v0, t0, lat, b0;
    b8.ready = 1'b1;
    b9.ready = 1'b1;
    clks(4);
    rst = 1'b0;
    clks(2);
    chk("rst_data", 32'(b8.data), 0);
    chk("rst_valid", 32'(b8.valid), 0);
    chk("rst_perr", 32'(b8.parity_err), 0);
    chk("rst_ferr", 32'(b8.frame_err), 0);
    chk("rst_ovr", 32'(b8.overrun), 0);
    chk("rst_brk", 32'(b8.brk), 0);
    chk("rst_valid9", 32'(b9.valid), 0);

    // 8N1 basic word with latency
    v0 = vcnt8; t0 = cyc;
    send(0, 9'h0A5, 8, 0, 0, 1, 1'b1, -1);
    clks(64);
    chk("a5_vcycles", 32'(vcnt8 - v0), 1);
    chk("a5_data", 32'(ld8), 32'h0A5);
    chk("a5_perr", 32'(lpe8), 0);
    chk("a5_ferr", 32'(lfe8), 0);
    chk("a5_ovr", 32'(lov8), 0);
    lat = vcyc8 - t0;
    ncmp++;
    assert (lat >= 305 && lat <= 315) else begin
      nerr++;
      $error("FAIL a5_latency: observed %0d expected about 311", lat);
    end

    // 9E2 correct and flipped parity
    v0 = vcnt9;
    send(1, 9'h1C3, 9, 2, 0, 2, 1'b1, -1);
    clks(64);
    chk("p9_count", 32'(vcnt9 - v0), 1);
    chk("p9_data", 32'(ld9), 32'h1C3);
    chk("p9_perr", 32'(lpe9), 0);
    chk("p9_ferr", 32'(lfe9), 0);
    send(1, 9'h1C3, 9, 2, 1, 2, 1'b1, -1);
    clks(64);
    chk("p9bad_data", 32'(ld9), 32'h1C3);
    chk("p9bad_perr", 32'(lpe9), 1);

    // false start glitch, then spike inside data bit 2
    v0 = vcnt8;
    rx8 = 1'b0; clks(10); rx8 = 1'b1;
    clks(64);
    chk("glitch_novalid", 32'(vcnt8 - v0), 0);
    send(0, 9'h096, 8, 0, 0, 1, 1'b1, 2);
    clks(64);
    chk("spike_count", 32'(vcnt8 - v0), 1);
    chk("spike_data", 32'(ld8), 32'h096);

    // overrun with ready low
    b8.ready = 1'b0;
    send(0, 9'h011, 8, 0, 0, 1, 1'b1, -1);
    clks(64);
    chk("ovr_first_valid", 32'(b8.valid), 1);
    chk("ovr_first_ovr", 32'(b8.overrun), 0);
    send(0, 9'h022, 8, 0, 0, 1, 1'b1, -1);
    clks(64);
    chk("ovr_valid", 32'(b8.valid), 1);
    chk("ovr_data", 32'(b8.data), 32'h011);
    chk("ovr_flag", 32'(b8.overrun), 1);
    b8.ready = 1'b1; clks(1); b8.ready = 1'b0;
    chk("ovr_acc_valid", 32'(b8.valid), 0);
    chk("ovr_acc_flag", 32'(b8.overrun), 0);
    b8.ready = 1'b1;

    // frame error then clean word
    v0 = vcnt8;
    send(0, 9'h055, 8, 0, 0, 1, 1'b0, -1);
    clks(64);
    chk("fe_count", 32'(vcnt8 - v0), 1);
    chk("fe_data", 32'(ld8), 32'h055);
    chk("fe_flag", 32'(lfe8), 1);
    send(0, 9'h066, 8, 0, 0, 1, 1'b1, -1);
    clks(64);
    chk("fe_next_data", 32'(ld8), 32'h066);
    chk("fe_next_flag", 32'(lfe8), 0);

    // reset in the middle of data bit 3 of 0x3C
    v0 = vcnt8;
    rx8 = 1'b0; clks(32);
    rx8 = 1'b0; clks(32);
    rx8 = 1'b0; clks(32);
    rx8 = 1'b1; clks(32);
    rx8 = 1'b1; clks(16);
    rst = 1'b1; clks(2);
    chk("midrst_valid", 32'(b8.valid), 0);
    rst = 1'b0; clks(64);
    send(0, 9'h07E, 8, 0, 0, 1, 1'b1, -1);
    clks(64);
    chk("midrst_count", 32'(vcnt8 - v0), 1);
    chk("midrst_data", 32'(ld8), 32'h07E);

    // break: line low for 20 bit times
    v0 = vcnt8; b0 = bcnt8;
    rx8 = 1'b0; clks(352);
`ifdef UART_RX_OS_BREAK_EN
    clks(288); rx8 = 1'b1; clks(640);
    chk("brk_pulses", 32'(bcnt8 - b0), 1);
    chk("brk_novalid", 32'(vcnt8 - v0), 0);
`else
    chk("brk_count", 32'(vcnt8 - v0), 1);
    chk("brk_data", 32'(ld8), 0);
    chk("brk_ferr", 32'(lfe8), 1);
    chk("brk_nopulse", 32'(bcnt8 - b0), 0);
    clks(288); rx8 = 1'b1; clks(512);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
